// File: rtl/serial_mult_host.sv
// Host side of the bit-serial multiplier link: shifts two N-bit operands out
// LSB-first under IE, collects the 2N-bit product from O, and checks it.
module serial_mult_host #(
   parameter int unsigned N          = 4,
   parameter int unsigned RESP_DELAY = 1
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [N-1:0]    OP_A,
   input  logic [N-1:0]    OP_B,
   output logic            IE,
   output logic            A,
   output logic            B,
   input  logic            O,
   output logic            RES_VALID,
   input  logic            RES_READY,
   output logic [2*N-1:0]  RES,
   output logic            MISMATCH,
   output logic            BUSY
);
   localparam int unsigned PW = 2 * N;
   localparam int unsigned CW = $clog2(PW + RESP_DELAY + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_RECV,
      S_DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  opa;
   logic [N-1:0]  opb;
   logic [N-1:0]  sha;
   logic [N-1:0]  shb;
   logic [PW-2:0] sr;
   logic [CW-1:0] cnt;
   logic [PW-1:0] prod_c;
   logic [PW-1:0] exp_c;

   assign REQ_READY = (state == S_IDLE);
   assign BUSY      = (state != S_IDLE);

   // Product including the bit arriving this cycle; the oldest bit ends up in bit 0.
   assign prod_c = {O, sr};
   assign exp_c  = PW'(opa) * PW'(opb);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         opa       <= '0;
         opb       <= '0;
         sha       <= '0;
         shb       <= '0;
         sr        <= '0;
         cnt       <= '0;
         IE        <= 1'b0;
         A         <= 1'b0;
         B         <= 1'b0;
         RES_VALID <= 1'b0;
         RES       <= '0;
         MISMATCH  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (REQ_VALID) begin
                  opa   <= OP_A;
                  opb   <= OP_B;
                  sha   <= OP_A >> 1;
                  shb   <= OP_B >> 1;
                  IE    <= 1'b1;
                  A     <= OP_A[0];
                  B     <= OP_B[0];
                  cnt   <= '0;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (cnt == CW'(N - 1)) begin
                  IE    <= 1'b0;
                  A     <= 1'b0;
                  B     <= 1'b0;
                  cnt   <= '0;
                  state <= (RESP_DELAY == 0) ? S_RECV : S_WAIT;
               end else begin
                  A   <= sha[0];
                  B   <= shb[0];
                  sha <= sha >> 1;
                  shb <= shb >> 1;
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (cnt == CW'(RESP_DELAY - 1)) begin
                  cnt   <= '0;
                  state <= S_RECV;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RECV: begin
               sr <= prod_c[PW-1:1];
               if (cnt == CW'(PW - 1)) begin
                  RES       <= prod_c;
                  RES_VALID <= 1'b1;
                  MISMATCH  <= (prod_c != exp_c);
                  cnt       <= '0;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  MISMATCH  <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_mult_host.sv
// Directed bench for serial_mult_host (N=4, RESP_DELAY=1) with a behavioural
// serial multiplier answering on O.
module tb_serial_mult_host;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ_VALID = 1'b0;
   logic       REQ_READY;
   logic [3:0] OP_A = '0;
   logic [3:0] OP_B = '0;
   logic       IE, A, B;
   logic       O = 1'b0;
   logic       RES_VALID;
   logic       RES_READY = 1'b1;
   logic [7:0] RES;
   logic       MISMATCH;
   logic       BUSY;

   serial_mult_host #(.N(4), .RESP_DELAY(1)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .OP_A(OP_A), .OP_B(OP_B), .IE(IE), .A(A), .B(B), .O(O),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES(RES),
      .MISMATCH(MISMATCH), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Responder: gathers A/B under IE, answers on O from the (RESP_DELAY+1)-th cycle after IE.
   logic [3:0] ra, rb;
   logic [7:0] rprod;
   logic [7:0] flip = '0;
   int         rcnt = 0;
   int         after = 0;
   bit         in_burst = 0;
   bit         ab_leak = 0;
   logic       prev_ie = 1'b0;

   initial begin
      forever begin
         @(negedge CLK);
         if (IE === 1'b1) begin
            if (prev_ie !== 1'b1) rcnt = 0;
            if (rcnt < 4) begin
               ra[rcnt] = A;
               rb[rcnt] = B;
            end
            rcnt++;
            in_burst = 1;
            after = 0;
            O = 1'b0;
         end else begin
            if (A === 1'b1 || B === 1'b1) ab_leak = 1;
            if (in_burst) begin
               after++;
               if (after == 1) rprod = ({4'b0, ra} * {4'b0, rb}) ^ flip;
               if (after >= 2 && after <= 9) O = rprod[after-2];
               else O = 1'b0;
               if (after > 9) in_burst = 0;
            end else begin
               O = 1'b0;
            end
         end
         prev_ie = IE;
      end
   end

   // One request; returns at the negedge of the first cycle RES_VALID is seen.
   task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [7:0] fl,
                      output int lat);
      int n;
      flip = fl;
      n = 0;
      while (REQ_READY !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("req_ready_wait", {31'b0, REQ_READY}, 32'd1);
      OP_A = a;
      OP_B = b;
      REQ_VALID = 1'b1;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      n = 0;
      while (RES_VALID !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      chk("res_valid_wait", {31'b0, RES_VALID}, 32'd1);
      lat = n;
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] flip;
      logic [7:0] res;
      logic       mis;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int lat;
      int n;
      logic [7:0] hold;

      tbl[0] = '{4'd3,  4'd5,  8'h00, 8'h0F, 1'b0};
      tbl[1] = '{4'd15, 4'd15, 8'h00, 8'hE1, 1'b0};
      tbl[2] = '{4'd0,  4'd9,  8'h00, 8'h00, 1'b0};
      tbl[3] = '{4'd3,  4'd5,  8'h04, 8'h0B, 1'b1};
      tbl[4] = '{4'd12, 4'd11, 8'h00, 8'h84, 1'b0};
      tbl[5] = '{4'd10, 4'd13, 8'h00, 8'h82, 1'b0};

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req_ready", {31'b0, REQ_READY}, 32'd1);
      chk("rst_busy", {31'b0, BUSY}, 32'd0);
      chk("rst_ie_a_b", {29'b0, IE, A, B}, 32'd0);
      chk("rst_res_valid", {31'b0, RES_VALID}, 32'd0);
      chk("rst_res", {24'b0, RES}, 32'd0);
      chk("rst_mismatch", {31'b0, MISMATCH}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // Table-driven transactions, consumer always ready
      for (int i = 0; i < 6; i++) begin
         txn(tbl[i].a, tbl[i].b, tbl[i].flip, lat);
         chk("res", {24'b0, RES}, {24'b0, tbl[i].res});
         chk("mismatch", {31'b0, MISMATCH}, {31'b0, tbl[i].mis});
         chk("latency", lat, 32'd13);
         chk("ie_cycles", rcnt, 32'd4);
         chk("a_bits", {28'b0, ra}, {28'b0, tbl[i].a});
         chk("b_bits", {28'b0, rb}, {28'b0, tbl[i].b});
         @(negedge CLK);
         chk("done_to_idle", {30'b0, REQ_READY, RES_VALID}, 32'd2);
      end

      // Backpressure: result held, new request ignored, release on RES_READY
      RES_READY = 1'b0;
      txn(4'd9, 4'd7, 8'h00, lat);
      hold = RES;
      chk("bp_res", {24'b0, hold}, 32'h3F);
      REQ_VALID = 1'b1;
      OP_A = 4'd1;
      OP_B = 4'd1;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         chk("bp_hold", {21'b0, RES_VALID, REQ_READY, BUSY, RES},
             {21'b0, 1'b1, 1'b0, 1'b1, hold});
      end
      REQ_VALID = 1'b0;
      RES_READY = 1'b1;
      @(negedge CLK);
      chk("bp_release", {21'b0, RES_VALID, REQ_READY, MISMATCH, RES},
          {21'b0, 1'b0, 1'b1, 1'b0, hold});
      chk("bp_no_accept", {31'b0, IE}, 32'd0);

      // Reset during receive cycle 3
      OP_A = 4'd9;
      OP_B = 4'd9;
      REQ_VALID = 1'b1;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      repeat (8) @(negedge CLK);
      chk("mid_reset_in_recv", {31'b0, BUSY}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_reset_outs", {19'b0, REQ_READY, BUSY, IE, A, B, RES_VALID, MISMATCH, RES},
          {19'b0, 1'b1, 6'b0, 8'h00});
      txn(4'd6, 4'd7, 8'h00, lat);
      chk("after_reset_res", {24'b0, RES}, 32'h2A);
      chk("after_reset_mis", {31'b0, MISMATCH}, 32'd0);
      @(negedge CLK);

      // Back-to-back with REQ_VALID held high
      OP_A = 4'd2;
      OP_B = 4'd3;
      REQ_VALID = 1'b1;
      n = 0;
      while (RES_VALID !== 1'b1 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      chk("b2b_first_res", {24'b0, RES}, 32'h06);
      OP_A = 4'd4;
      OP_B = 4'd4;
      n = 0;
      while (IE !== 1'b1 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      chk("b2b_gap_ok", {31'b0, n >= 2 && n < 60}, 32'd1);
      n = 0;
      while (RES_VALID !== 1'b1 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      REQ_VALID = 1'b0;
      chk("b2b_second_res", {24'b0, RES}, 32'h10);
      chk("b2b_second_mis", {31'b0, MISMATCH}, 32'd0);
      repeat (3) @(negedge CLK);

      chk("ab_low_when_ie_low", {31'b0, ab_leak}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
